// File: rtl/eeg_pea_pkg.sv
// Shared definitions for the PE-array distributor: FSM states, default
// parameters and the bit layout of a buffered word.
package eeg_pea_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_PE_ROW = 4;
  localparam int DEF_PE_COL = 4;
  localparam int DEF_ACT_DW = 8;
  localparam int DEF_WEI_DW = 8;
  localparam int DEF_ACT_IW = 12;
  localparam int DEF_WEI_IW = 3;
  localparam int DEF_BUF_NW = 4;
  localparam int DEF_CNT_DW = 16;

  // Word layout from LSB: act_dat, wei_dat, act_inf, wei_inf, act_lst, wei_lst.
  function automatic int off_wei_dat(int adw);
    return adw;
  endfunction

  function automatic int off_act_inf(int adw, int wdw);
    return adw + wdw;
  endfunction

  function automatic int off_wei_inf(int adw, int wdw, int aiw);
    return adw + wdw + aiw;
  endfunction

  function automatic int off_act_lst(int adw, int wdw, int aiw, int wiw);
    return adw + wdw + aiw + wiw;
  endfunction

  function automatic int off_wei_lst(int adw, int wdw, int aiw, int wiw);
    return adw + wdw + aiw + wiw + 1;
  endfunction

  function automatic int word_w(int adw, int wdw, int aiw, int wiw);
    return adw + wdw + aiw + wiw + 2;
  endfunction

endpackage

// File: rtl/eeg_pea_dist_fifo.sv
// First-word fall-through FIFO feeding one PE; DEPTH must be a power of two
// so the pointers wrap naturally.
module eeg_pea_dist_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count already makes it invisible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/eeg_pea_dist.sv
// Distributes activation/weight pairs into a PE_ROW x PE_COL array of FWFT
// FIFOs. Optional stall counters are built with EEG_PEA_DIST_PERF_EN.
module eeg_pea_dist
  import eeg_pea_pkg::*;
#(
  parameter int PE_ROW = DEF_PE_ROW,
  parameter int PE_COL = DEF_PE_COL,
  parameter int ACT_DW = DEF_ACT_DW,
  parameter int WEI_DW = DEF_WEI_DW,
  parameter int ACT_IW = DEF_ACT_IW,
  parameter int WEI_IW = DEF_WEI_IW,
  parameter int BUF_NW = DEF_BUF_NW,
  parameter int CNT_DW = DEF_CNT_DW
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     cfg_start,
  input  logic                                     cfg_mode,
  output logic                                     is_idle,
  input  logic [PE_COL-1:0]                        act_vld,
  output logic [PE_COL-1:0]                        act_rdy,
  input  logic [PE_COL-1:0]                        act_lst,
  input  logic [PE_COL-1:0][ACT_DW-1:0]            act_dat,
  input  logic [PE_COL-1:0][ACT_IW-1:0]            act_inf,
  input  logic [PE_COL-1:0][PE_ROW-1:0]            wei_vld,
  output logic [PE_COL-1:0][PE_ROW-1:0]            wei_rdy,
  input  logic [PE_COL-1:0][PE_ROW-1:0]            wei_lst,
  input  logic [PE_COL-1:0][PE_ROW-1:0][WEI_DW-1:0] wei_dat,
  input  logic [PE_COL-1:0][PE_ROW-1:0][WEI_IW-1:0] wei_inf,
  output logic [PE_ROW-1:0][PE_COL-1:0]            pe_vld,
  input  logic [PE_ROW-1:0][PE_COL-1:0]            pe_rdy,
  output logic [PE_ROW-1:0][PE_COL-1:0]            pe_act_lst,
  output logic [PE_ROW-1:0][PE_COL-1:0]            pe_wei_lst,
  output logic [PE_ROW-1:0][PE_COL-1:0][ACT_DW-1:0] pe_act_dat,
  output logic [PE_ROW-1:0][PE_COL-1:0][WEI_DW-1:0] pe_wei_dat,
  output logic [PE_ROW-1:0][PE_COL-1:0][ACT_IW-1:0] pe_act_inf,
  output logic [PE_ROW-1:0][PE_COL-1:0][WEI_IW-1:0] pe_wei_inf,
  output logic [PE_COL-1:0][CNT_DW-1:0]            stall_cnt
);

  localparam int WORD_W = word_w(ACT_DW, WEI_DW, ACT_IW, WEI_IW);
  localparam int O_WD   = off_wei_dat(ACT_DW);
  localparam int O_AI   = off_act_inf(ACT_DW, WEI_DW);
  localparam int O_WI   = off_wei_inf(ACT_DW, WEI_DW, ACT_IW);
  localparam int O_AL   = off_act_lst(ACT_DW, WEI_DW, ACT_IW, WEI_IW);
  localparam int O_WL   = off_wei_lst(ACT_DW, WEI_DW, ACT_IW, WEI_IW);

  state_e                          state;
  logic                            mode_q;
  logic [PE_COL-1:0]               done_q;
  logic [PE_COL-1:0]               done_nxt;
  logic [PE_COL-1:0]               fire;
  logic [PE_COL-1:0]               col_full;
  logic                            fire_all;
  logic                            run;
  logic [PE_ROW-1:0][PE_COL-1:0]   fifo_full;
  logic [PE_ROW-1:0][PE_COL-1:0]   fifo_empty;

  assign run      = (state == ST_RUN);
  assign is_idle  = (state == ST_IDLE);
  assign act_rdy  = fire;
  assign done_nxt = done_q | (fire & act_lst);

  // Fire uses this cycle's full flags, so a full FIFO blocks even while it pops.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_full = '0;
    fire     = '0;
    wei_rdy  = '0;
    fire_all = run && (&act_vld) && (&wei_vld[0]) && !(|fifo_full);
    for (int j = 0; j < PE_COL; j++) begin
      for (int i = 0; i < PE_ROW; i++) col_full[j] = col_full[j] | fifo_full[i][j];
      fire[j] = mode_q ? fire_all
                       : (run && act_vld[j] && (&wei_vld[j]) && !col_full[j]);
      wei_rdy[j] = mode_q ? {PE_ROW{fire_all && (j == 0)}} : {PE_ROW{fire[j]}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
      done_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cfg_start) begin
          state  <= ST_RUN;
          mode_q <= cfg_mode;
          done_q <= '0;
        end
        ST_RUN: begin
          done_q <= done_nxt;
          if (&done_nxt) state <= ST_DRAIN;
        end
        ST_DRAIN: if (&fifo_empty) begin
          state  <= ST_IDLE;
          done_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < PE_ROW; i++) begin : g_row
    for (genvar j = 0; j < PE_COL; j++) begin : g_col
      logic [WORD_W-1:0] wdata;
      logic [WORD_W-1:0] rdata;
      logic              empty;

      // Row-shared mode takes every row's weight from column 0.
      assign wdata = mode_q
        ? {wei_lst[0][i], act_lst[j], wei_inf[0][i], act_inf[j], wei_dat[0][i], act_dat[j]}
        : {wei_lst[j][i], act_lst[j], wei_inf[j][i], act_inf[j], wei_dat[j][i], act_dat[j]};

      eeg_pea_dist_fifo #(
        .DATA_WIDTH (WORD_W),
        .DEPTH      (BUF_NW)
      ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fire[j]),
        .wdata (wdata),
        .pop   (pe_vld[i][j] && pe_rdy[i][j]),
        .rdata (rdata),
        .empty (empty),
        .full  (fifo_full[i][j])
      );

      assign fifo_empty[i][j] = empty;
      assign pe_vld[i][j]     = ~empty;
      assign pe_act_dat[i][j] = rdata[0 +: ACT_DW];
      assign pe_wei_dat[i][j] = rdata[O_WD +: WEI_DW];
      assign pe_act_inf[i][j] = rdata[O_AI +: ACT_IW];
      assign pe_wei_inf[i][j] = rdata[O_WI +: WEI_IW];
      assign pe_act_lst[i][j] = rdata[O_AL];
      assign pe_wei_lst[i][j] = rdata[O_WL];
    end
  end

`ifdef EEG_PEA_DIST_PERF_EN
  logic [PE_COL-1:0][CNT_DW-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      for (int j = 0; j < PE_COL; j++) begin
        if (is_idle && cfg_start)
          stall_q[j] <= '0;
        else if (run && act_vld[j] && !fire[j] && (stall_q[j] != '1))
          stall_q[j] <= stall_q[j] + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_eeg_pea_dist.sv
// Directed self-checking bench for eeg_pea_dist at default parameters.
module tb_eeg_pea_dist;

  localparam int R = 4;
  localparam int C = 4;
`ifdef EEG_PEA_DIST_PERF_EN
  localparam logic [15:0] EXP_STALL1 = 16'd1;
`else
  localparam logic [15:0] EXP_STALL1 = 16'd0;
`endif

  logic clk, rst_n, cfg_start, cfg_mode, is_idle;
  logic [C-1:0]             act_vld, act_rdy, act_lst;
  logic [C-1:0][7:0]        act_dat;
  logic [C-1:0][11:0]       act_inf;
  logic [C-1:0][R-1:0]      wei_vld, wei_rdy, wei_lst;
  logic [C-1:0][R-1:0][7:0] wei_dat;
  logic [C-1:0][R-1:0][2:0] wei_inf;
  logic [R-1:0][C-1:0]      pe_vld, pe_rdy, pe_act_lst, pe_wei_lst;
  logic [R-1:0][C-1:0][7:0] pe_act_dat, pe_wei_dat;
  logic [R-1:0][C-1:0][11:0] pe_act_inf;
  logic [R-1:0][C-1:0][2:0] pe_wei_inf;
  logic [C-1:0][15:0]       stall_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  eeg_pea_dist dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .is_idle(is_idle),
    .act_vld(act_vld), .act_rdy(act_rdy), .act_lst(act_lst), .act_dat(act_dat), .act_inf(act_inf),
    .wei_vld(wei_vld), .wei_rdy(wei_rdy), .wei_lst(wei_lst), .wei_dat(wei_dat), .wei_inf(wei_inf),
    .pe_vld(pe_vld), .pe_rdy(pe_rdy), .pe_act_lst(pe_act_lst), .pe_wei_lst(pe_wei_lst),
    .pe_act_dat(pe_act_dat), .pe_wei_dat(pe_wei_dat), .pe_act_inf(pe_act_inf),
    .pe_wei_inf(pe_wei_inf), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    act_vld = '0; act_lst = '0; act_dat = '0; act_inf = '0;
    wei_vld = '0; wei_lst = '0; wei_dat = '0; wei_inf = '0;
  endtask

  task automatic start_run(input logic m);
    cfg_mode  = m;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    tests_run++;
    if (is_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_run: is_idle got %b want 0", is_idle);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = 1'b0; pe_rdy = '1;
    clear_inputs();
    #3;
    tests_run++;
    if ({is_idle, act_rdy, wei_rdy} !== {1'b1, 4'h0, 16'h0}) begin
      tests_failed++;
      $display("FAIL reset_ctrl: idle/act_rdy/wei_rdy got %b/%h/%h want 1/0/0", is_idle, act_rdy, wei_rdy);
    end
    tests_run++;
    if (pe_vld !== 16'h0 || stall_cnt !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_out: pe_vld got %h stall_cnt got %h want 0", pe_vld, stall_cnt);
    end
    #9 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mode0_fire();
    logic [31:0] got_a, got_w;
    start_run(1'b0);
    act_vld[0] = 1'b1; act_dat[0] = 8'h12; act_inf[0] = 12'hABC;
    wei_vld[0] = 4'hF;
    for (int i = 0; i < R; i++) wei_dat[0][i] = 8'(i + 1);
    #1;
    tests_run++;
    if (act_rdy !== 4'b0001 || wei_rdy !== 16'h000F) begin
      tests_failed++;
      $display("FAIL mode0_rdy: act_rdy %b wei_rdy %h want 0001 000f", act_rdy, wei_rdy);
    end
    tick();
    clear_inputs();
    for (int i = 0; i < R; i++) begin
      got_a[i*8 +: 8] = pe_act_dat[i][0];
      got_w[i*8 +: 8] = pe_wei_dat[i][0];
    end
    tests_run++;
    if (pe_vld !== 16'h1111) begin
      tests_failed++;
      $display("FAIL mode0_pe_vld: got %h want 1111", pe_vld);
    end
    tests_run++;
    if (got_a !== 32'h12121212 || got_w !== 32'h04030201 || pe_act_inf[2][0] !== 12'hABC) begin
      tests_failed++;
      $display("FAIL mode0_data: act %h wei %h inf %h want 12121212 04030201 abc", got_a, got_w, pe_act_inf[2][0]);
    end
    tick();
    tests_run++;
    if (pe_vld !== 16'h0 || act_rdy !== 4'h0) begin
      tests_failed++;
      $display("FAIL mode0_one_cycle: pe_vld %h act_rdy %b want 0 0", pe_vld, act_rdy);
    end
  endtask

  task automatic test_partial_weight();
    act_vld[1] = 1'b1;
    wei_vld[1] = 4'b1011;
    #1;
    tests_run++;
    if (act_rdy !== 4'h0 || wei_rdy !== 16'h0) begin
      tests_failed++;
      $display("FAIL partial_rdy: act_rdy %b wei_rdy %h want 0 0", act_rdy, wei_rdy);
    end
    tick();
    clear_inputs();
    tests_run++;
    if (pe_vld !== 16'h0) begin
      tests_failed++;
      $display("FAIL partial_push: pe_vld got %h want 0", pe_vld);
    end
  endtask

  task automatic test_stall();
    pe_rdy[0][0] = 1'b0;
    act_vld[0] = 1'b1; wei_vld[0] = 4'hF;
    for (int k = 0; k < 4; k++) begin
      act_dat[0] = 8'(k);
      #1;
      tests_run++;
      if (act_rdy[0] !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_fill%0d: act_rdy[0] got %b want 1", k, act_rdy[0]);
      end
      tick();
    end
    act_dat[0] = 8'd4;
    #1;
    tests_run++;
    if (act_rdy[0] !== 1'b0 || wei_rdy[0] !== 4'h0) begin
      tests_failed++;
      $display("FAIL stall_full: act_rdy[0] %b wei_rdy[0] %h want 0 0", act_rdy[0], wei_rdy[0]);
    end
    tick();
    tests_run++;
    if (stall_cnt[0] !== EXP_STALL1 || pe_act_dat[0][0] !== 8'd0) begin
      tests_failed++;
      $display("FAIL stall_cnt: cnt %0d head %0d want %0d 0", stall_cnt[0], pe_act_dat[0][0], EXP_STALL1);
    end
    pe_rdy[0][0] = 1'b1;
    #1;
    tests_run++;
    if (act_rdy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_full_pop: act_rdy[0] got %b want 0", act_rdy[0]);
    end
    tick();
    tests_run++;
    if (act_rdy[0] !== 1'b1 || pe_act_dat[0][0] !== 8'd1) begin
      tests_failed++;
      $display("FAIL stall_resume: act_rdy[0] %b head %0d want 1 1", act_rdy[0], pe_act_dat[0][0]);
    end
    tick();
    clear_inputs();
    for (int k = 2; k <= 4; k++) begin
      tests_run++;
      if (pe_vld[0][0] !== 1'b1 || pe_act_dat[0][0] !== 8'(k)) begin
        tests_failed++;
        $display("FAIL stall_order%0d: vld %b head %0d want 1 %0d", k, pe_vld[0][0], pe_act_dat[0][0], k);
      end
      tick();
    end
    tests_run++;
    if (pe_vld !== 16'h0) begin
      tests_failed++;
      $display("FAIL stall_empty: pe_vld got %h want 0", pe_vld);
    end
  endtask

  task automatic test_drain();
    pe_rdy = '0;
    act_vld = '1; act_lst = '1; wei_vld = '1;
    #1;
    tests_run++;
    if (act_rdy !== 4'hF) begin
      tests_failed++;
      $display("FAIL drain_fire: act_rdy got %b want 1111", act_rdy);
    end
    tick();
    #1;
    tests_run++;
    if (act_rdy !== 4'h0 || is_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_nofire: act_rdy %b is_idle %b want 0 0", act_rdy, is_idle);
    end
    tests_run++;
    if (pe_vld !== 16'hFFFF || pe_act_lst !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL drain_words: pe_vld %h pe_act_lst %h want ffff ffff", pe_vld, pe_act_lst);
    end
    tick();
    clear_inputs();
    tests_run++;
    if (is_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_hold: is_idle got %b want 0", is_idle);
    end
    pe_rdy = '1;
    tick();
    tests_run++;
    if (pe_vld !== 16'h0 || is_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain_empty: pe_vld %h is_idle %b want 0 0", pe_vld, is_idle);
    end
    tick();
    tests_run++;
    if (is_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_idle: is_idle got %b want 1", is_idle);
    end
  endtask

  task automatic test_mode1_shared();
    logic [R-1:0][C-1:0][7:0] exp_w, exp_a;
    start_run(1'b1);
    act_vld = '1;
    for (int j = 0; j < C; j++) act_dat[j] = 8'(8'h20 + j);
    wei_vld[0] = 4'hF;
    for (int i = 0; i < R; i++) wei_dat[0][i] = 8'(8'h70 + i);
    cfg_start = 1'b1; cfg_mode = 1'b0;
    #1;
    tests_run++;
    if (act_rdy !== 4'hF || wei_rdy !== 16'h000F) begin
      tests_failed++;
      $display("FAIL mode1_rdy: act_rdy %b wei_rdy %h want 1111 000f", act_rdy, wei_rdy);
    end
    tick();
    cfg_start = 1'b0;
    clear_inputs();
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        exp_w[i][j] = 8'(8'h70 + i);
        exp_a[i][j] = 8'(8'h20 + j);
      end
    tests_run++;
    if (pe_vld !== 16'hFFFF || pe_wei_dat !== exp_w || pe_act_dat !== exp_a) begin
      tests_failed++;
      $display("FAIL mode1_data: vld %h wei %h act %h want ffff %h %h", pe_vld, pe_wei_dat, pe_act_dat, exp_w, exp_a);
    end
    act_vld = '1; act_lst = '1; wei_vld[0] = 4'hF;
    #1;
    tests_run++;
    if (act_rdy !== 4'hF || is_idle !== 1'b0) begin
      tests_failed++;
      $display("FAIL mode1_held: act_rdy %b is_idle %b want 1111 0", act_rdy, is_idle);
    end
    tick();
    clear_inputs();
    for (int k = 0; k < 10 && is_idle !== 1'b1; k++) tick();
    tests_run++;
    if (is_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL mode1_finish: is_idle got %b want 1 within 10 cycles", is_idle);
    end
  endtask

  task automatic test_reset_mid_run();
    start_run(1'b0);
    pe_rdy = '0;
    act_vld[0] = 1'b1; wei_vld[0] = 4'hF;
    repeat (3) tick();
    clear_inputs();
    tests_run++;
    if (pe_vld !== 16'h1111) begin
      tests_failed++;
      $display("FAIL midrun_buffered: pe_vld got %h want 1111", pe_vld);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (pe_vld !== 16'h0 || is_idle !== 1'b1 || act_rdy !== 4'h0) begin
      tests_failed++;
      $display("FAIL midrun_async: pe_vld %h is_idle %b act_rdy %b want 0 1 0", pe_vld, is_idle, act_rdy);
    end
    #2 rst_n = 1'b1;
    pe_rdy = '1;
    tick();
    tests_run++;
    if (pe_vld !== 16'h0 || is_idle !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrun_after: pe_vld %h is_idle %b want 0 1", pe_vld, is_idle);
    end
  endtask

  initial begin
    test_reset();
    test_mode0_fire();
    test_partial_weight();
    test_stall();
    test_drain();
    test_mode1_shared();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
